// File: rtl/lcd_init_sequencer.sv
// HD44780-style LCD front end: runs the power-on init ROM, then forwards a USB
// FIFO byte stream to the panel as data writes, with 0x00 as an instruction escape.
module lcd_init_sequencer #(
    parameter int E_CYCLES = 6,
    parameter int T_POR    = 360000,
    parameter int T_INIT   = 98400,
    parameter int T_LONG   = 39360,
    parameter int T_SHORT  = 960
) (
    input  logic       FIFO_CLK,
    input  logic       FIFO_RSTn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DB,
    output logic       init_done,
    output logic       busy
);

    localparam logic [2:0] POR_WAIT  = 3'd0;
    localparam logic [2:0] INIT_LOAD = 3'd1;
    localparam logic [2:0] IDLE      = 3'd2;
    localparam logic [2:0] ESC       = 3'd3;
    localparam logic [2:0] SETUP     = 3'd4;
    localparam logic [2:0] STROBE    = 3'd5;
    localparam logic [2:0] HOLD      = 3'd6;
    localparam logic [2:0] WAIT      = 3'd7;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared counter times POR, the E pulse and every post-write wait.
    localparam int T_MAX = max_of(max_of(max_of(T_POR, T_INIT), max_of(T_LONG, T_SHORT)), E_CYCLES);
    localparam int CNT_W = $clog2(T_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t POR_LAST   = cnt_t'(T_POR - 1);
    localparam cnt_t E_LAST     = cnt_t'(E_CYCLES - 1);
    localparam cnt_t INIT_LAST  = cnt_t'(T_INIT - 1);
    localparam cnt_t LONG_LAST  = cnt_t'(T_LONG - 1);
    localparam cnt_t SHORT_LAST = cnt_t'(T_SHORT - 1);

    localparam logic [2:0] INIT_LAST_IDX = 3'd5;

    function automatic logic [7:0] init_rom(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h38;
            3'd1:    return 8'h38;
            3'd2:    return 8'h38;
            3'd3:    return 8'h0C;
            3'd4:    return 8'h01;
            3'd5:    return 8'h06;
            default: return 8'h00;
        endcase
    endfunction

    logic [2:0] state, state_nxt;
    cnt_t       cnt, cnt_nxt;
    logic [2:0] idx, idx_nxt;
    logic       rs_nxt, e_nxt, done_nxt;
    logic [7:0] db_nxt;
    logic       accept;
    logic       slow_instr;
    cnt_t       wait_last;

    assign in_ready = init_done && (state == IDLE || state == ESC);
    assign busy     = !(state == IDLE || state == ESC);
    assign LCD_RW   = 1'b0;
    assign accept   = in_valid && in_ready;

    // Clear display and return home need the long settle time.
    assign slow_instr = !LCD_RS && (LCD_DB == 8'h01 || LCD_DB == 8'h02 || LCD_DB == 8'h03);

    always_comb begin
        if (!init_done)
            wait_last = INIT_LAST;
        else if (slow_instr)
            wait_last = LONG_LAST;
        else
            wait_last = SHORT_LAST;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        rs_nxt    = LCD_RS;
        db_nxt    = LCD_DB;
        e_nxt     = LCD_E;
        done_nxt  = init_done;

        case (state)
            POR_WAIT: begin
                if (cnt == POR_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = INIT_LOAD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            INIT_LOAD: begin
                db_nxt    = init_rom(idx);
                rs_nxt    = 1'b0;
                state_nxt = SETUP;
            end
            IDLE: begin
                if (accept) begin
                    if (in_data == 8'h00) begin
                        state_nxt = ESC;
                    end else begin
                        db_nxt    = in_data;
                        rs_nxt    = 1'b1;
                        state_nxt = SETUP;
                    end
                end
            end
            ESC: begin
                // After the escape, 0x00 is a literal data zero; anything else is an instruction.
                if (accept) begin
                    db_nxt    = in_data;
                    rs_nxt    = (in_data == 8'h00);
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                e_nxt     = 1'b1;
                cnt_nxt   = '0;
                state_nxt = STROBE;
            end
            STROBE: begin
                if (cnt == E_LAST) begin
                    e_nxt     = 1'b0;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                cnt_nxt   = wait_last;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (init_done) begin
                    state_nxt = IDLE;
                end else if (idx == INIT_LAST_IDX) begin
                    idx_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx + 3'd1;
                    state_nxt = INIT_LOAD;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = POR_WAIT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge FIFO_CLK or negedge FIFO_RSTn) begin
        if (!FIFO_RSTn) begin
            state     <= POR_WAIT;
            cnt       <= '0;
            idx       <= '0;
            LCD_RS    <= 1'b0;
            LCD_DB    <= 8'h00;
            LCD_E     <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            LCD_RS    <= rs_nxt;
            LCD_DB    <= db_nxt;
            LCD_E     <= e_nxt;
            init_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Self-checking bench for lcd_init_sequencer: expected LCD writes are queued as
// stimulus is driven and matched against strobes captured from the bus.
module tb_lcd_init_sequencer;

    localparam int E_CYCLES = 6;
    localparam int T_POR    = 20;
    localparam int T_INIT   = 10;
    localparam int T_LONG   = 8;
    localparam int T_SHORT  = 4;
    localparam int BUDGET   = 400;
    localparam logic [7:0] E_W = 8'(E_CYCLES);

    logic       FIFO_CLK  = 1'b0;
    logic       FIFO_RSTn = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;
    logic [7:0] LCD_DB;
    logic       init_done;
    logic       busy;

    typedef struct packed {
        logic       rs;
        logic [7:0] db;
    } wr_t;

    typedef struct packed {
        logic        rs;
        logic [7:0]  db;
        logic [7:0]  width;
        logic        stable;
        logic [31:0] rise_cyc;
    } obs_t;

    wr_t  exp_q[$];
    obs_t obs_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    lcd_init_sequencer #(
        .E_CYCLES (E_CYCLES),
        .T_POR    (T_POR),
        .T_INIT   (T_INIT),
        .T_LONG   (T_LONG),
        .T_SHORT  (T_SHORT)
    ) dut (
        .FIFO_CLK  (FIFO_CLK),
        .FIFO_RSTn (FIFO_RSTn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_E     (LCD_E),
        .LCD_DB    (LCD_DB),
        .init_done (init_done),
        .busy      (busy)
    );

    always #5 FIFO_CLK = ~FIFO_CLK;

    always @(posedge FIFO_CLK) cyc <= cyc + 1;

    // Bus monitor: one record per LCD_E pulse, sampled on the falling clock edge.
    obs_t cur = '0;
    bit   in_strobe = 1'b0;
    always @(negedge FIFO_CLK) begin
        if (LCD_E && !in_strobe) begin
            in_strobe    = 1'b1;
            cur.rs       = LCD_RS;
            cur.db       = LCD_DB;
            cur.width    = 8'd1;
            cur.stable   = 1'b1;
            cur.rise_cyc = cyc;
        end else if (LCD_E) begin
            cur.width = cur.width + 8'd1;
            if ({LCD_RS, LCD_DB} !== {cur.rs, cur.db}) cur.stable = 1'b0;
        end else if (in_strobe) begin
            in_strobe = 1'b0;
            obs_q.push_back(cur);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit keep, output int acc, output bit ok);
        ok  = 1'b0;
        acc = -1;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            if (in_ready) begin
                acc = cyc + 1;
                ok  = 1'b1;
            end
            @(negedge FIFO_CLK);
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_obs(output obs_t o, output bit ok);
        ok = 1'b0;
        o  = '0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            if (obs_q.size() > 0) begin
                o  = obs_q.pop_front();
                ok = 1'b1;
            end else begin
                @(negedge FIFO_CLK);
            end
        end
    endtask

    task automatic wait_ready(output int c, output bit ok);
        ok = 1'b0;
        c  = -1;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            if (in_ready) begin
                c  = cyc;
                ok = 1'b1;
            end else begin
                @(negedge FIFO_CLK);
            end
        end
    endtask

    task automatic test_reset();
        FIFO_RSTn = 1'b0;
        repeat (3) @(negedge FIFO_CLK);
        n_checks++;
        if ({LCD_E, LCD_RS, LCD_RW, LCD_DB} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_bus: got E/RS/RW/DB=%h required %h", {LCD_E, LCD_RS, LCD_RW, LCD_DB}, 11'h000);
        end
        n_checks++;
        if ({in_ready, init_done, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_status: got ready/done/busy=%b required 001", {in_ready, init_done, busy});
        end
    endtask

    task automatic test_init(input string tag);
        logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        obs_t o;
        wr_t  e;
        bit   ok;
        int   rel, prev_rise, exp_rise, c;
        for (int i = 0; i < 6; i++) exp_q.push_back('{rs: 1'b0, db: rom[i]});
        rel       = cyc;
        prev_rise = 0;
        FIFO_RSTn = 1'b1;
        @(negedge FIFO_CLK);
        n_checks++;
        if ({in_ready, init_done, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL %s_por_status: got ready/done/busy=%b required 001", tag, {in_ready, init_done, busy});
        end
        for (int i = 0; i < 6; i++) begin
            wait_obs(o, ok);
            n_checks++;
            if (!ok || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s_strobe%0d: got no strobe (timeout=%0d) required a write", tag, i, !ok);
            end else begin
                e = exp_q.pop_front();
                if ({o.rs, o.db, o.width, o.stable} !== {e.rs, e.db, E_W, 1'b1}) begin
                    n_fail++;
                    $display("FAIL %s_strobe%0d: got rs/db/width/stable=%h required %h",
                             tag, i, {o.rs, o.db, o.width, o.stable}, {e.rs, e.db, E_W, 1'b1});
                end
                exp_rise = (i == 0) ? rel + T_POR + 2 : prev_rise + 3 + E_CYCLES + T_INIT;
                n_checks++;
                if (int'(o.rise_cyc) !== exp_rise) begin
                    n_fail++;
                    $display("FAIL %s_rise%0d: got cycle %0d required %0d", tag, i, o.rise_cyc, exp_rise);
                end
                prev_rise = int'(o.rise_cyc);
            end
        end
        c = -1;
        for (int i = 0; i < BUDGET && c < 0; i++) begin
            if (init_done) c = cyc;
            else @(negedge FIFO_CLK);
        end
        n_checks++;
        if (c !== prev_rise + 1 + E_CYCLES + T_INIT) begin
            n_fail++;
            $display("FAIL %s_done_time: got cycle %0d required %0d", tag, c, prev_rise + 1 + E_CYCLES + T_INIT);
        end
        n_checks++;
        if ({in_ready, init_done, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL %s_done_status: got ready/done/busy=%b required 110", tag, {in_ready, init_done, busy});
        end
    endtask

    task automatic test_data_write();
        obs_t o;
        wr_t  e;
        bit   ok;
        int   acc, c;
        exp_q.push_back('{rs: 1'b1, db: 8'h41});
        send_byte(8'h41, 1'b0, acc, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL data_accept: got no accept required accept of 41");
        end
        n_checks++;
        if ({LCD_E, LCD_RS, LCD_DB} !== {1'b0, 1'b1, 8'h41}) begin
            n_fail++;
            $display("FAIL data_setup: got E/RS/DB=%h required %h", {LCD_E, LCD_RS, LCD_DB}, {1'b0, 1'b1, 8'h41});
        end
        wait_obs(o, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if (!ok || {o.rs, o.db, o.width, o.stable} !== {e.rs, e.db, E_W, 1'b1}) begin
            n_fail++;
            $display("FAIL data_strobe: got rs/db/width/stable=%h required %h",
                     {o.rs, o.db, o.width, o.stable}, {e.rs, e.db, E_W, 1'b1});
        end
        n_checks++;
        if (int'(o.rise_cyc) !== acc + 1) begin
            n_fail++;
            $display("FAIL data_rise: got cycle %0d required %0d", o.rise_cyc, acc + 1);
        end
        wait_ready(c, ok);
        n_checks++;
        if (c !== acc + 2 + E_CYCLES + T_SHORT) begin
            n_fail++;
            $display("FAIL data_ready_time: got cycle %0d required %0d", c, acc + 2 + E_CYCLES + T_SHORT);
        end
        n_checks++;
        if ({LCD_RS, LCD_DB, busy} !== {1'b1, 8'h41, 1'b0}) begin
            n_fail++;
            $display("FAIL data_retain: got RS/DB/busy=%h required %h", {LCD_RS, LCD_DB, busy}, {1'b1, 8'h41, 1'b0});
        end
    endtask

    task automatic test_escape_instruction();
        obs_t o;
        wr_t  e;
        bit   ok;
        int   acc, c;
        send_byte(8'h00, 1'b0, acc, ok);
        n_checks++;
        if (!ok || {in_ready, busy, LCD_E} !== 3'b100) begin
            n_fail++;
            $display("FAIL esc_state: got ready/busy/E=%b required 100", {in_ready, busy, LCD_E});
        end
        exp_q.push_back('{rs: 1'b0, db: 8'h01});
        send_byte(8'h01, 1'b0, acc, ok);
        wait_obs(o, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if (!ok || {o.rs, o.db, o.width, o.stable} !== {e.rs, e.db, E_W, 1'b1}) begin
            n_fail++;
            $display("FAIL esc_instr_strobe: got rs/db/width/stable=%h required %h",
                     {o.rs, o.db, o.width, o.stable}, {e.rs, e.db, E_W, 1'b1});
        end
        wait_ready(c, ok);
        n_checks++;
        if (c !== acc + 2 + E_CYCLES + T_LONG) begin
            n_fail++;
            $display("FAIL esc_long_wait: got cycle %0d required %0d", c, acc + 2 + E_CYCLES + T_LONG);
        end
        n_checks++;
        if (obs_q.size() !== 0) begin
            n_fail++;
            $display("FAIL esc_extra_strobe: got %0d extra strobes required 0", obs_q.size());
        end
    endtask

    task automatic test_literal_zero();
        obs_t o;
        wr_t  e;
        bit   ok;
        int   acc, c;
        send_byte(8'h00, 1'b0, acc, ok);
        exp_q.push_back('{rs: 1'b1, db: 8'h00});
        send_byte(8'h00, 1'b0, acc, ok);
        wait_obs(o, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if (!ok || {o.rs, o.db, o.width, o.stable} !== {e.rs, e.db, E_W, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_strobe: got rs/db/width/stable=%h required %h",
                     {o.rs, o.db, o.width, o.stable}, {e.rs, e.db, E_W, 1'b1});
        end
        wait_ready(c, ok);
        n_checks++;
        if (c !== acc + 2 + E_CYCLES + T_SHORT) begin
            n_fail++;
            $display("FAIL zero_short_wait: got cycle %0d required %0d", c, acc + 2 + E_CYCLES + T_SHORT);
        end
        n_checks++;
        if (obs_q.size() !== 0) begin
            n_fail++;
            $display("FAIL zero_extra_strobe: got %0d extra strobes required 0", obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        wr_t  e;
        bit   ok1, ok2, ok;
        int   acc1, acc2, c;
        exp_q.push_back('{rs: 1'b1, db: 8'h42});
        exp_q.push_back('{rs: 1'b1, db: 8'h43});
        send_byte(8'h42, 1'b1, acc1, ok1);
        send_byte(8'h43, 1'b0, acc2, ok2);
        n_checks++;
        if (!ok1 || !ok2 || acc2 !== acc1 + 3 + E_CYCLES + T_SHORT) begin
            n_fail++;
            $display("FAIL b2b_accept_gap: got accepts at %0d,%0d required gap %0d", acc1, acc2, 3 + E_CYCLES + T_SHORT);
        end
        for (int i = 0; i < 2; i++) begin
            wait_obs(o, ok);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_checks++;
            if (!ok || {o.rs, o.db, o.width, o.stable} !== {e.rs, e.db, E_W, 1'b1}) begin
                n_fail++;
                $display("FAIL b2b_strobe%0d: got rs/db/width/stable=%h required %h",
                         i, {o.rs, o.db, o.width, o.stable}, {e.rs, e.db, E_W, 1'b1});
            end
            n_checks++;
            if (int'(o.rise_cyc) !== ((i == 0) ? acc1 : acc2) + 1) begin
                n_fail++;
                $display("FAIL b2b_rise%0d: got cycle %0d required %0d", i, o.rise_cyc, ((i == 0) ? acc1 : acc2) + 1);
            end
        end
        wait_ready(c, ok);
        n_checks++;
        if (!ok || obs_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_extra_strobe: got %0d extra strobes (ready=%0d) required 0", obs_q.size(), ok);
        end
    endtask

    task automatic test_reset_mid_strobe();
        obs_t o;
        wr_t  e;
        bit   ok;
        int   acc;
        exp_q.push_back('{rs: 1'b1, db: 8'h55});
        send_byte(8'h55, 1'b0, acc, ok);
        @(negedge FIFO_CLK);
        n_checks++;
        if (LCD_E !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_strobe_high: got E=%b required 1", LCD_E);
        end
        #2 FIFO_RSTn = 1'b0;
        #1;
        n_checks++;
        if ({LCD_E, LCD_RS, LCD_DB, in_ready, init_done, busy} !== {1'b0, 1'b0, 8'h00, 3'b001}) begin
            n_fail++;
            $display("FAIL midrst_async_clear: got E/RS/DB/ready/done/busy=%h required %h",
                     {LCD_E, LCD_RS, LCD_DB, in_ready, init_done, busy}, {1'b0, 1'b0, 8'h00, 3'b001});
        end
        @(negedge FIFO_CLK);
        wait_obs(o, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if (!ok || {o.rs, o.db} !== {e.rs, e.db}) begin
            n_fail++;
            $display("FAIL midrst_aborted_write: got rs/db=%h required %h", {o.rs, o.db}, {e.rs, e.db});
        end
        repeat (2) @(negedge FIFO_CLK);
        test_init("reinit");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge FIFO_CLK);
        test_reset();
        test_init("init");
        test_data_write();
        test_escape_instruction();
        test_literal_zero();
        test_back_to_back();
        test_reset_mid_strobe();
        n_checks++;
        if (exp_q.size() !== 0 || obs_q.size() !== 0 || LCD_RW !== 1'b0) begin
            n_fail++;
            $display("FAIL final_drain: got exp=%0d obs=%0d RW=%b required 0/0/0", exp_q.size(), obs_q.size(), LCD_RW);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
